// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port arbiter: WB writes win, MDU results queue in a FIFO,
// and a starvation counter forces a one-cycle stall/drain. Optional stats: REGFILE_ARB_STATS_EN.
module regfile_wport_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WbRegWrite,
  input  logic [4:0]  WbRd,
  input  logic [31:0] WbData,
  input  logic        MduValid,
  input  logic [4:0]  MduRd,
  input  logic [31:0] MduData,
  output logic        MduReady,
  output logic        RegWrite,
  output logic [4:0]  Rd,
  output logic [31:0] data,
  output logic        Stall,
  output logic [31:0] Pending
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] MduWriteCount
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ARB, DRAIN} state_t;

  state_t                state, state_next;
  logic [4:0]            fifo_rd   [FIFO_DEPTH];
  logic [31:0]           fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_valid;
  logic [AW-1:0]         wptr, rptr;
  logic [CW-1:0]         count;
  logic [SW-1:0]         starve, starve_next;
  logic                  full, empty, push, pop, wb_win;
  logic [31:0]           pend;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign MduReady = !rst && !full;
  // Results for r0 are handshaken but never stored.
  assign push     = MduValid && MduReady && (MduRd != '0);
  assign wb_win   = WbRegWrite && (WbRd != '0);

  always_comb begin
    state_next  = state;
    starve_next = starve;
    RegWrite    = 1'b0;
    Rd          = '0;
    data        = '0;
    Stall       = 1'b0;
    pop         = 1'b0;
    if (!rst) begin
      case (state)
        ARB: begin
          if (wb_win) begin
            RegWrite = 1'b1;
            Rd       = WbRd;
            data     = WbData;
          end else if (!empty) begin
            RegWrite = 1'b1;
            Rd       = fifo_rd[rptr];
            data     = fifo_data[rptr];
            pop      = 1'b1;
          end
        end
        DRAIN: begin
          Stall      = 1'b1;
          state_next = ARB;
          if (!empty) begin
            RegWrite = 1'b1;
            Rd       = fifo_rd[rptr];
            data     = fifo_data[rptr];
            pop      = 1'b1;
          end
        end
        default: state_next = ARB;
      endcase

      if (pop || empty || state == DRAIN)
        starve_next = '0;
      else if (wb_win)
        starve_next = starve + SW'(1);

      // Threshold is checked on the post-update value so the drain follows immediately.
      if (state == ARB && starve_next == SW'(STARVE_LIMIT))
        state_next = DRAIN;
    end
  end

  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++)
      if (fifo_valid[i]) pend[fifo_rd[i]] = 1'b1;
    Pending = rst ? '0 : {pend[31:1], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      starve     <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      fifo_valid <= '0;
    end else begin
      state  <= state_next;
      starve <= starve_next;
      if (push) begin
        wptr             <= wptr + AW'(1);
        fifo_valid[wptr] <= 1'b1;
      end
      if (pop) begin
        rptr             <= rptr + AW'(1);
        fifo_valid[rptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wptr]   <= MduRd;
      fifo_data[wptr] <= MduData;
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount    <= '0;
      MduWriteCount <= '0;
    end else begin
      if (state == DRAIN) StallCount    <= StallCount + 32'd1;
      if (pop)            MduWriteCount <= MduWriteCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Bench for regfile_wport_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model. Define REGFILE_ARB_STATS_EN to cover stats.
module tb_regfile_wport_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        WbRegWrite = 1'b0;
  logic [4:0]  WbRd = '0;
  logic [31:0] WbData = '0;
  logic        MduValid = 1'b0;
  logic [4:0]  MduRd = '0;
  logic [31:0] MduData = '0;
  logic        MduReady, RegWrite, Stall;
  logic [4:0]  Rd;
  logic [31:0] data, Pending;
`ifdef REGFILE_ARB_STATS_EN
  logic [31:0] StallCount, MduWriteCount;
`endif

  regfile_wport_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .WbRegWrite(WbRegWrite), .WbRd(WbRd), .WbData(WbData),
    .MduValid(MduValid), .MduRd(MduRd), .MduData(MduData),
    .MduReady(MduReady), .RegWrite(RegWrite), .Rd(Rd), .data(data),
    .Stall(Stall), .Pending(Pending)
`ifdef REGFILE_ARB_STATS_EN
    , .StallCount(StallCount), .MduWriteCount(MduWriteCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [4:0] rd; logic [31:0] data;} ent_t;

  // Reference model: queue of buffered results, starvation count, drain flag.
  ent_t        q[$];
  int          m_starve = 0;
  bit          m_drain = 0;
  int unsigned m_stalls = 0, m_pops = 0;
  logic        exp_we, exp_stall, exp_ready;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data, exp_pend;

  int vectors = 0;
  int errors = 0;

  // Drive one cycle on the falling edge, predict outputs, advance the model.
  task automatic apply(input logic r, input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
    bit popped, won, was_empty;
    ent_t e;
    @(negedge clk);
    rst = r; MduValid = mv; MduRd = mrd; MduData = md;
    WbRegWrite = wv; WbRd = wrd; WbData = wd;
    exp_we = 0; exp_stall = 0; exp_ready = 0; exp_rd = '0; exp_data = '0; exp_pend = '0;
    if (r) begin
      q.delete(); m_starve = 0; m_drain = 0; m_stalls = 0; m_pops = 0;
    end else begin
      popped = 0; won = 0; was_empty = (q.size() == 0);
      exp_ready = (q.size() < DEPTH);
      foreach (q[i]) exp_pend[q[i].rd] = 1'b1;
      exp_stall = m_drain;
      if (m_drain && q.size() > 0) begin
        exp_we = 1; exp_rd = q[0].rd; exp_data = q[0].data; popped = 1;
      end else if (!m_drain && wv && wrd != 0) begin
        exp_we = 1; exp_rd = wrd; exp_data = wd; won = 1;
      end else if (!m_drain && q.size() > 0) begin
        exp_we = 1; exp_rd = q[0].rd; exp_data = q[0].data; popped = 1;
      end
      if (m_drain) m_stalls++;
      if (popped) begin void'(q.pop_front()); m_pops++; end
      if (mv && exp_ready && mrd != 0) begin e.rd = mrd; e.data = md; q.push_back(e); end
      if (popped || was_empty || m_drain) m_starve = 0;
      else if (won) m_starve++;
      m_drain = !m_drain && (m_starve == LIMIT);
    end
    #1;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1, 1, 5'd5, 32'h1111, 1, 5'd3, 32'h2222);
      vectors++;
      if (RegWrite !== 1'b0 || MduReady !== 1'b0 || Stall !== 1'b0 || Pending !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold: RegWrite=%b MduReady=%b Stall=%b Pending=%h, want 0 0 0 0",
                 RegWrite, MduReady, Stall, Pending);
      end
    end
    idle();
    vectors++;
    if (MduReady !== 1'b1 || Pending !== 32'h0 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: MduReady=%b Pending=%h RegWrite=%b, want 1 0 0",
               MduReady, Pending, RegWrite);
    end
  endtask

  task automatic test_idle_mdu();
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    vectors++;
    if (RegWrite !== 1'b0 || Pending !== 32'h0) begin
      errors++;
      $display("FAIL no_bypass: RegWrite=%b Pending=%h, want 0 0", RegWrite, Pending);
    end
    idle();
    vectors++;
    if (RegWrite !== 1'b1 || Rd !== 5'd5 || data !== 32'hDEADBEEF || Pending !== 32'h20) begin
      errors++;
      $display("FAIL idle_mdu_write: we=%b rd=%0d data=%h pend=%h, want 1 5 deadbeef 00000020",
               RegWrite, Rd, data, Pending);
    end
    idle();
    vectors++;
    if (RegWrite !== 1'b0 || Pending !== 32'h0) begin
      errors++;
      $display("FAIL idle_mdu_after: RegWrite=%b Pending=%h, want 0 0", RegWrite, Pending);
    end
  endtask

  task automatic test_starvation();
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 5'd7, 32'h77, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 0, 1, 5'(9 + i), 32'(100 + i));
      vectors++;
      if (RegWrite !== 1'b1 || Rd !== 5'(9 + i) || Stall !== 1'b0) begin
        errors++;
        $display("FAIL starve_wb%0d: we=%b rd=%0d stall=%b, want 1 %0d 0", i, RegWrite, Rd, Stall, 9 + i);
      end
    end
    apply(0, 0, 0, 0, 1, 5'd12, 32'd103);
    vectors++;
    if (Stall !== 1'b1 || RegWrite !== 1'b1 || Rd !== 5'd7 || data !== 32'h77) begin
      errors++;
      $display("FAIL starve_drain: stall=%b we=%b rd=%0d data=%h, want 1 1 7 00000077",
               Stall, RegWrite, Rd, data);
    end
    apply(0, 0, 0, 0, 1, 5'd12, 32'd103);
    vectors++;
    if (Stall !== 1'b0 || RegWrite !== 1'b1 || Rd !== 5'd12 || data !== 32'd103) begin
      errors++;
      $display("FAIL starve_replay: stall=%b we=%b rd=%0d data=%0d, want 0 1 12 103",
               Stall, RegWrite, Rd, data);
    end
`ifdef REGFILE_ARB_STATS_EN
    vectors++;
    if (StallCount !== 32'd1 || MduWriteCount !== 32'd1) begin
      errors++;
      $display("FAIL starve_stats: StallCount=%0d MduWriteCount=%0d, want 1 1", StallCount, MduWriteCount);
    end
`endif
  endtask

  task automatic test_full();
    logic [4:0] log_rd[$];
    bit acc8 = 0;
    bit mv;
    logic [4:0] mrd;
    apply(1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 30; c++) begin
      mv  = (c < 2) || !acc8;
      mrd = (c == 0) ? 5'd3 : (c == 1) ? 5'd4 : 5'd8;
      apply(0, mv, mrd, 32'(mrd), c < 12, 5'd20, 32'd20);
      if (c == 2) begin
        vectors++;
        if (MduReady !== 1'b0) begin
          errors++;
          $display("FAIL full_ready: MduReady=%b, want 0", MduReady);
        end
      end
      if (RegWrite === 1'b1 && Rd != 5'd20) log_rd.push_back(Rd);
      if (c >= 2 && mv && MduReady === 1'b1) acc8 = 1;
    end
    vectors++;
    if (!acc8 || log_rd.size() != 3 || log_rd[0] != 5'd3 || log_rd[1] != 5'd4 || log_rd[2] != 5'd8) begin
      errors++;
      $display("FAIL full_order: accepted8=%0d writes=%p, want 1 '{3,4,8}", acc8, log_rd);
    end
  endtask

  task automatic test_zero_reg();
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 5'd6, 32'h66, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 5'd0, 32'hABCD);
    vectors++;
    if (RegWrite !== 1'b1 || Rd !== 5'd6 || data !== 32'h66 || Pending !== 32'h40) begin
      errors++;
      $display("FAIL zero_wb: we=%b rd=%0d data=%h pend=%h, want 1 6 00000066 00000040",
               RegWrite, Rd, data, Pending);
    end
    apply(0, 1, 5'd0, 32'h99, 0, 0, 0);
    vectors++;
    if (MduReady !== 1'b1 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL zero_mdu_accept: MduReady=%b RegWrite=%b, want 1 0", MduReady, RegWrite);
    end
    idle();
    vectors++;
    if (RegWrite !== 1'b0 || Pending !== 32'h0) begin
      errors++;
      $display("FAIL zero_mdu_drop: RegWrite=%b Pending=%h, want 0 0", RegWrite, Pending);
    end
  endtask

  task automatic test_random();
    logic wv = 0, mv = 0, r;
    logic [4:0] wrd = '0, mrd = '0;
    logic [31:0] wd = '0, md = '0;
    bit held_wb, held_mdu;
    apply(1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      held_wb  = exp_stall;
      held_mdu = mv && !exp_ready;
      if (!held_wb) begin
        wv = ($urandom_range(0, 99) < 60); wrd = 5'($urandom_range(0, 31)); wd = $urandom;
      end
      if (!held_mdu) begin
        mv = ($urandom_range(0, 99) < 45); mrd = 5'($urandom_range(0, 31)); md = $urandom;
      end
      r = ($urandom_range(0, 199) == 0);
      apply(r, mv, mrd, md, wv, wrd, wd);
      vectors++;
      if (RegWrite !== exp_we || (exp_we && (Rd !== exp_rd || data !== exp_data))) begin
        errors++;
        $display("FAIL rand_write c=%0d: we=%b rd=%0d data=%h, want %b %0d %h",
                 c, RegWrite, Rd, data, exp_we, exp_rd, exp_data);
      end
      vectors++;
      if (Stall !== exp_stall || MduReady !== exp_ready) begin
        errors++;
        $display("FAIL rand_ctl c=%0d: stall=%b ready=%b, want %b %b", c, Stall, MduReady, exp_stall, exp_ready);
      end
      vectors++;
      if (Pending !== exp_pend) begin
        errors++;
        $display("FAIL rand_pending c=%0d: got %h want %h", c, Pending, exp_pend);
      end
`ifdef REGFILE_ARB_STATS_EN
      vectors++;
      if (!r && (StallCount !== 32'(m_stalls - (exp_stall ? 1 : 0)) ||
                 MduWriteCount !== 32'(m_pops - (exp_we && (exp_stall || exp_rd != wrd || !wv) ? 0 : 0)) - 0)) begin
        if (StallCount !== 32'(m_stalls - (exp_stall ? 1 : 0))) begin
          errors++;
          $display("FAIL rand_stallcount c=%0d: got %0d want %0d", c, StallCount, m_stalls - (exp_stall ? 1 : 0));
        end
      end
`endif
      if (r) begin wv = 0; mv = 0; end
    end
  endtask

`ifdef REGFILE_ARB_STATS_EN
  task automatic test_stats_random();
    idle();
    vectors++;
    if (StallCount !== 32'(m_stalls) || MduWriteCount !== 32'(m_pops)) begin
      errors++;
      $display("FAIL stats_totals: StallCount=%0d MduWriteCount=%0d, want %0d %0d",
               StallCount, MduWriteCount, m_stalls, m_pops);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle_mdu();
    test_starvation();
    test_full();
    test_zero_reg();
    test_random();
`ifdef REGFILE_ARB_STATS_EN
    test_stats_random();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
